// File: rtl/rf_pkg.sv
// rf_pkg -- shared definitions for the 2-read/1-write register file.
//   rf_state_e : encoding of the clear sequencer (RF_IDLE / RF_CLEAR).
//   rf_is_last : true when a clear pointer addresses the final entry.
package rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Final entry is the all-ones address, so no depth arithmetic is needed.
  function automatic logic rf_is_last(input logic [15:0] ptr, input int unsigned aw);
    logic last_s;
    last_s = 1'b1;
    for (int unsigned i = 0; i < aw; i++) begin
      last_s = last_s & ptr[i];
    end
    return last_s;
  endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// rf_clear_fsm -- sequencer that walks every entry of the array writing zero.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset; (re)starts a clear from entry 0
//   clr      in   request a clear; ignored while a clear is running
//   busy     out  high exactly while the clear is running
//   clr_ptr  out  entry being zeroed this cycle
//   clr_we   out  zero-write strobe for entry clr_ptr
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_ptr,
  output logic                  clr_we
);

  rf_state_e             state_r;
  rf_state_e             state_nxt_s;
  logic [ADDR_WIDTH-1:0] clr_ptr_r;
  logic [ADDR_WIDTH-1:0] clr_ptr_nxt_s;
  logic                  ptr_last_s;

  assign ptr_last_s = rf_is_last(16'(clr_ptr_r), ADDR_WIDTH);

  // State and pointer registers; reset forces a fresh clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RF_CLEAR;
      clr_ptr_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      clr_ptr_r <= clr_ptr_nxt_s;
    end
  end

  // Next-state: the pointer holds at the last entry rather than wrapping.
  always_comb begin
    state_nxt_s   = state_r;
    clr_ptr_nxt_s = clr_ptr_r;
    case (state_r)
      RF_IDLE: begin
        if (clr) begin
          state_nxt_s   = RF_CLEAR;
          clr_ptr_nxt_s = '0;
        end else begin
          state_nxt_s   = RF_IDLE;
        end
      end
      RF_CLEAR: begin
        if (ptr_last_s) begin
          state_nxt_s   = RF_IDLE;
        end else begin
          clr_ptr_nxt_s = clr_ptr_r + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_nxt_s   = RF_IDLE;
        clr_ptr_nxt_s = '0;
      end
    endcase
  end

  assign busy    = (state_r == RF_CLEAR);
  assign clr_we  = (state_r == RF_CLEAR);
  assign clr_ptr = clr_ptr_r;

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w -- 2 combinational read ports, 1 write port, with a hardware
// clear sequence that zeroes the array after reset or on request.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to
// a read port addressing the written entry.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   clr               single-cycle request to zero the whole array
//   raddr1 / rdata1   read port 1 (zero latency)
//   raddr2 / rdata2   read port 2 (zero latency)
//   waddr/wdata/wen   write port, accepted when not busy
//   busy              clear sequence in progress; reads return 0, writes dropped
module regfile_2r1w
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wen,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  busy_s;
  logic                  clr_we_s;
  logic [ADDR_WIDTH-1:0] clr_ptr_s;
  logic                  wr_ok_s;
  logic                  zero_w_s;
  logic                  zero_r1_s;
  logic                  zero_r2_s;
  logic [DATA_WIDTH-1:0] rdata1_s;
  logic [DATA_WIDTH-1:0] rdata2_s;

  rf_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy_s),
    .clr_ptr (clr_ptr_s),
    .clr_we  (clr_we_s)
  );

  assign zero_w_s  = (ZERO_REG != 0) && (waddr  == '0);
  assign zero_r1_s = (ZERO_REG != 0) && (raddr1 == '0);
  assign zero_r2_s = (ZERO_REG != 0) && (raddr2 == '0);

  // A user write commits only outside reset and outside a clear.
  assign wr_ok_s = wen & ~busy_s & ~rst & ~zero_w_s;

  // Array storage: clear zero-writes take the port; user writes otherwise.
  always_ff @(posedge clk) begin
    if (!rst && clr_we_s) begin
      mem_r[clr_ptr_s] <= '0;
    end else if (wr_ok_s) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port 1: zero during clear and for the hardwired entry.
  always_comb begin
    rdata1_s = '0;
    if (busy_s || zero_r1_s) begin
      rdata1_s = '0;
    end else begin
`ifdef RF_BYPASS_EN
      if (wr_ok_s && (waddr == raddr1)) begin
        rdata1_s = wdata;
      end else begin
        rdata1_s = mem_r[raddr1];
      end
`else
      rdata1_s = mem_r[raddr1];
`endif
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rdata2_s = '0;
    if (busy_s || zero_r2_s) begin
      rdata2_s = '0;
    end else begin
`ifdef RF_BYPASS_EN
      if (wr_ok_s && (waddr == raddr2)) begin
        rdata2_s = wdata;
      end else begin
        rdata2_s = mem_r[raddr2];
      end
`else
      rdata2_s = mem_r[raddr2];
`endif
    end
  end

  assign rdata1 = rdata1_s;
  assign rdata2 = rdata2_s;
  assign busy   = busy_s;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w -- directed self-checking bench for regfile_2r1w (defaults).
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wen;
  logic        busy;

  int n_checks;
  int n_errors;
  int n_busy;

  regfile_2r1w dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .waddr  (waddr),
    .wdata  (wdata),
    .wen    (wen),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high from the current sample on, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      check(tag, rdata1, 32'h0000_0000);
      check(tag, rdata2, 32'h0000_0000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; clr = 1'b0; wen = 1'b0;
    raddr1 = 5'd5; raddr2 = 5'd6; waddr = 5'd0; wdata = 32'h0;

    // Reset: clear runs for exactly 32 cycles, reads forced to 0 meanwhile.
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd_during_clear", rdata1, 32'h0000_0000);
    count_busy(n_busy);
    check("rst_busy_len", 32'(n_busy), 32'd32);
    check("idle_busy", 32'(busy), 32'd0);
    check_all_zero("rst_all_zero");

    // Write/read on both ports; same-cycle value depends on bypass.
    raddr1 = 5'd5; raddr2 = 5'd5;
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    #1;
`ifdef RF_BYPASS_EN
    check("wr5_same_cycle", rdata1, 32'hDEAD_BEEF);
`else
    check("wr5_same_cycle", rdata1, 32'h0000_0000);
`endif
    tick();
    wen = 1'b0;
    check("wr5_rd1", rdata1, 32'hDEAD_BEEF);
    check("wr5_rd2", rdata2, 32'hDEAD_BEEF);

    // Hardwired zero entry: write discarded, no bypass either.
    raddr1 = 5'd0;
    wen = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678;
    #1;
    check("zero_same_cycle", rdata1, 32'h0000_0000);
    tick();
    wen = 1'b0;
    check("zero_after", rdata1, 32'h0000_0000);

    // Bypass vs old value at address 7.
    wr(5'd7, 32'h0000_0077);
    raddr1 = 5'd7; raddr2 = 5'd5;
    wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
    #1;
`ifdef RF_BYPASS_EN
    check("byp7_same_cycle", rdata1, 32'hA5A5_A5A5);
`else
    check("byp7_same_cycle", rdata1, 32'h0000_0077);
`endif
    check("byp7_other_port", rdata2, 32'hDEAD_BEEF);
    tick();
    wen = 1'b0;
    check("byp7_after", rdata1, 32'hA5A5_A5A5);

    // Clear/write collision: write and re-clr during busy are ignored.
    wr(5'd3, 32'h0000_0011);
    raddr1 = 5'd3;
    #1;
    check("fill3", rdata1, 32'h0000_0011);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_0022; clr = 1'b1;
    #1;
    check("clr_rd_forced0", rdata1, 32'h0000_0000);
    tick();
    wen = 1'b0; clr = 1'b0;
    count_busy(n_busy);
    check("clr_busy_len", 32'(n_busy + 1), 32'd32);
    raddr1 = 5'd3; raddr2 = 5'd7;
    #1;
    check("clr_addr3", rdata1, 32'h0000_0000);
    check("clr_addr7", rdata2, 32'h0000_0000);

    // Fill every entry, then reset at clear cycle 10.
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'h0101_0101 * 32'(i));
    end
    raddr1 = 5'd31; raddr2 = 5'd9;
    #1;
    check("fill31", rdata1, 32'h1F1F_1F1F);
    check("fill9", rdata2, 32'h0909_0909);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
    end
    check("mid_clear_busy", 32'(busy), 32'd1);
    rst = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 32'h0000_0055;
    tick();
    rst = 1'b0; wen = 1'b0;
    count_busy(n_busy);
    check("rst_mid_busy_len", 32'(n_busy), 32'd32);
    check_all_zero("rst_mid_all_zero");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: entry width in bits.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, entry 0 is hardwired to zero.
REQ-004 SHALL have ports as follows; one clock, reset synchronous active-high.
  clk     in   1           rising-edge clock.
  rst     in   1           synchronous active-high reset.
  clr     in   1           single-cycle request to zero the whole array.
  raddr1  in   ADDR_WIDTH  read port 1 address.
  rdata1  out  DATA_WIDTH  read port 1 data, combinational.
  raddr2  in   ADDR_WIDTH  read port 2 address.
  rdata2  out  DATA_WIDTH  read port 2 data, combinational.
  waddr   in   ADDR_WIDTH  write address.
  wdata   in   DATA_WIDTH  write data.
  wen     in   1           write enable.
  busy    out  1           clear sequence in progress.

Function
REQ-005 SHALL write wdata to entry waddr at the rising edge of clk when wen=1 and busy=0.
REQ-006 SHALL return entry raddrN on rdataN in the same cycle (zero-latency read); reads of a location written at the same edge return the new value from the next cycle onward.
REQ-007 SHALL discard writes to address 0 and return 0 for reads of address 0 when ZERO_REG=1.
REQ-008 SHALL implement a two-state clear FSM: IDLE and CLEAR, with pointer clr_ptr of ADDR_WIDTH bits.
REQ-009 SHALL go IDLE->CLEAR on clr=1 in IDLE, with clr_ptr loaded to 0.
REQ-010 SHALL write zero to entry clr_ptr each cycle in CLEAR and increment clr_ptr.
REQ-011 SHALL return to IDLE at the edge that clears entry 2**ADDR_WIDTH-1; a clear SHALL take exactly 2**ADDR_WIDTH cycles.
REQ-012 SHALL drive busy=1 exactly while in CLEAR.
REQ-013 SHALL ignore wen in CLEAR; the write is dropped, not deferred.
REQ-014 SHALL drive rdata1 and rdata2 to 0 in CLEAR regardless of address.
REQ-015 SHALL ignore clr asserted while in CLEAR; the sequence does not restart.
REQ-016 SHALL make clr_ptr wrap-free: no increment past 2**ADDR_WIDTH-1 is ever observed.

Reset
REQ-017 SHALL enter CLEAR with clr_ptr=0 and busy=1 on the edge where rst=1, so the array is fully zeroed after reset.
REQ-018 SHALL restart the clear from entry 0 when rst is asserted mid-CLEAR.
REQ-019 SHALL take priority of rst over clr and wen in the same cycle.

Configuration
REQ-020 SHALL compile write-to-read bypass only when macro RF_BYPASS_EN is defined.
REQ-021 With RF_BYPASS_EN defined: if wen=1, busy=0, waddr=raddrN and the ZERO_REG rule does not block the write, rdataN SHALL equal wdata in that same cycle.
REQ-022 Without RF_BYPASS_EN: rdataN SHALL show the old stored value until the edge, per REQ-006.

Structure
REQ-023 SHALL place the FSM state encoding (RF_IDLE=1'b0, RF_CLEAR=1'b1) in shared package rf_pkg.
REQ-024 SHALL place the clear FSM and pointer in one sub-module, rf_clear_fsm, which outputs busy, clr_ptr and clr_we.

Verification
REQ-025 Reset: pulse rst for 1 cycle -> busy=1 for exactly 32 cycles (defaults); then all 32 entries read 0.
REQ-026 Write/read: write 0xDEADBEEF to addr 5 -> next cycle rdata1 (raddr1=5) and rdata2 (raddr2=5) both read 0xDEADBEEF.
REQ-027 Zero register: wen=1, waddr=0, wdata=0x12345678 -> rdata1 with raddr1=0 stays 0.
REQ-028 Bypass: wen=1, waddr=raddr1=7, wdata=0xA5A5A5A5 -> same-cycle rdata1=0xA5A5A5A5 with RF_BYPASS_EN; old value without it.
REQ-029 Clear and write collision: fill addr 3=0x11; pulse clr; during busy, write addr 3=0x22 and pulse clr again -> busy lasts 32 cycles; addr 3 reads 0 afterward.
REQ-030 Reset mid-clear: assert rst at clear cycle 10 -> busy stays high 32 further cycles; all entries read 0.
